// File: rtl/noc_pkg.sv
// noc_pkg: shared link constants and packet type for the NIC, local port and router
package noc_pkg;
  localparam int DATA_W = 64;
  localparam int VC_BIT = DATA_W - 1;
  localparam bit VC_EVEN = 1'b0;
  localparam bit VC_ODD = 1'b1;
  typedef logic [DATA_W-1:0] packet_t;
endpackage

// File: rtl/router_local_port_if.sv
// router_local_port_if: NIC link and router-core signals of the local port
interface router_local_port_if #(
  parameter int DATA_W = noc_pkg::DATA_W,
  parameter int CNT_W = 8
);
  logic polarity;
  logic net_so;
  logic net_ro;
  logic net_si;
  logic net_ri;
  logic out_wr;
  logic [DATA_W-1:0] net_do;
  logic [DATA_W-1:0] net_di;
  logic [DATA_W-1:0] in_data_even;
  logic [DATA_W-1:0] in_data_odd;
  logic [DATA_W-1:0] out_data;
  logic [1:0] in_valid;
  logic [1:0] in_pop;
  logic [1:0] out_space;
  logic [CNT_W-1:0] drop_in;
  logic [CNT_W-1:0] drop_out;
  modport slave (
    output polarity, net_ro, net_si, net_di, in_valid, in_data_even, in_data_odd,
           out_space, drop_in, drop_out,
    input  net_so, net_do, net_ri, in_pop, out_wr, out_data
  );
  modport master (
    input  polarity, net_ro, net_si, net_di, in_valid, in_data_even, in_data_odd,
           out_space, drop_in, drop_out,
    output net_so, net_do, net_ri, in_pop, out_wr, out_data
  );
endinterface

// File: rtl/vc_slot.sv
// vc_slot: single-entry packet buffer with load, clear and full flag
module vc_slot #(
  parameter int W = noc_pkg::DATA_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         full,
  output logic [W-1:0] q
);
  // load only happens when empty and clear only when full, so they never collide
  always_ff @(posedge clk)
    if (reset) begin
      full <= 1'b0;
      q <= '0;
    end else if (load) begin
      full <= 1'b1;
      q <= d;
    end else if (clear) begin
      full <= 1'b0;
    end
endmodule

// File: rtl/router_local_port.sv
// router_local_port: router-side terminal of the NIC link with per-VC single-entry buffers
module router_local_port #(
  parameter int DATA_W = noc_pkg::DATA_W,
  parameter int CNT_W = 8
) (
  input logic clk,
  input logic reset,
  router_local_port_if.slave bus
);
  import noc_pkg::*;
  logic pol;
  logic accept;
  logic out_vc;
  logic out_drop;
  logic [1:0] in_full;
  logic [1:0] out_full;
  logic [1:0] in_load;
  logic [1:0] in_clr;
  logic [1:0] in_bad;
  logic [1:0] out_load;
  logic [1:0] out_clr;
  logic [DATA_W-1:0] in_q [2];
  logic [DATA_W-1:0] out_q [2];
  logic [CNT_W-1:0] drop_in_q;
  logic [CNT_W-1:0] drop_out_q;
  logic [CNT_W:0] in_sum;
  assign bus.polarity = pol;
  assign bus.net_ro = !reset && !in_full[pol];
  assign accept = bus.net_so && bus.net_ro;
  assign bus.net_si = !reset && bus.net_ri && out_full[pol];
  assign bus.net_di = bus.net_si ? out_q[pol] : '0;
  assign out_vc = bus.out_data[DATA_W-1];
  assign out_drop = bus.out_wr && out_full[out_vc];
  assign in_clr = bus.in_pop & in_full;
  assign in_bad = bus.in_pop & ~in_full;
  assign in_sum = {1'b0, drop_in_q} + (CNT_W+1)'(in_bad[0]) + (CNT_W+1)'(in_bad[1]);
  for (genvar v = 0; v < 2; v++) begin : g_vc
    assign in_load[v] = accept && (pol == 1'(v));
    assign out_load[v] = bus.out_wr && (out_vc == 1'(v)) && !out_full[v];
    assign out_clr[v] = bus.net_si && (pol == 1'(v));
    vc_slot #(.W(DATA_W)) u_in (
      .clk(clk), .reset(reset), .load(in_load[v]), .clear(in_clr[v]),
      .d(bus.net_do), .full(in_full[v]), .q(in_q[v])
    );
    vc_slot #(.W(DATA_W)) u_out (
      .clk(clk), .reset(reset), .load(out_load[v]), .clear(out_clr[v]),
      .d(bus.out_data), .full(out_full[v]), .q(out_q[v])
    );
  end
  assign bus.in_valid = in_full;
  assign bus.in_data_even = in_q[VC_EVEN];
  assign bus.in_data_odd = in_q[VC_ODD];
  assign bus.out_space = ~out_full;
  assign bus.drop_in = drop_in_q;
  assign bus.drop_out = drop_out_q;
  // link polarity alternates every cycle, selecting the VC allowed on the link
  always_ff @(posedge clk)
    pol <= reset ? 1'b0 : !pol;
  // saturating drop counters: pops of empty input slots and writes into full output slots
  always_ff @(posedge clk)
    if (reset) begin
      drop_in_q <= '0;
      drop_out_q <= '0;
    end else begin
      drop_in_q <= in_sum[CNT_W] ? '1 : in_sum[CNT_W-1:0];
      drop_out_q <= (out_drop && drop_out_q != '1) ? drop_out_q + 1'b1 : drop_out_q;
    end
endmodule
